// File: rtl/mem_access_if.sv
// ---------------------------------------------------------------------------
// mem_access_if
// Bundles the signals of the data-memory stage.
// The bundle covers two groups of signals:
//   - the execute-side enabled/completed handshake, with the instruction info
//     and the write-back result;
//   - the synchronous single-port data RAM bus.
//
// Modports:
//   slave  : the mem_access stage itself. It takes the request and
//            mem_rdata, and drives the result and the RAM strobes.
//   master : the environment. That is the core sequencer together with the
//            data RAM.
//
// Parameter:
//   ADDR_W : word-address width of the data RAM
// ---------------------------------------------------------------------------
interface mem_access_if #(
    parameter int ADDR_W = 12
);
    // Execute-side request
    logic              enabled;
    logic              is_load;
    logic              is_store;
    logic [2:0]        funct3;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [31:0]       alu_result;

    // Write-back side result
    logic              completed;
    logic [31:0]       rd;
    logic              fault;

    // Data RAM bus
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  enabled, is_load, is_store, funct3, addr, wdata, alu_result,
        input  mem_rdata,
        output completed, rd, fault,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output enabled, is_load, is_store, funct3, addr, wdata, alu_result,
        output mem_rdata,
        input  completed, rd, fault,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access
// Data-memory stage of the multicycle core. It sits between execute and
// write-back.
//
// When the stage is enabled it does one of three things:
//   - a load: reads a synchronous RAM of RD_LATENCY cycles, then sign- or
//     zero-extends the selected lane;
//   - a store: writes the RAM with byte write enables;
//   - a non-memory instruction: passes alu_result straight through.
// A misaligned or illegal access raises fault and never touches the RAM.
//
// Ports:
//   clk  : clock
//   rstn : synchronous active-low reset
//   bus  : mem_access_if.slave, which carries:
//            - the request: enabled, is_load, is_store, funct3, addr,
//              wdata, alu_result;
//            - the result: completed, rd, fault;
//            - the RAM bus: mem_en, mem_we, mem_addr, mem_wdata, mem_rdata.
//
// Parameters:
//   ADDR_W     : RAM word-address width (2**ADDR_W words of 32 bits)
//   RD_LATENCY : 1..4. This is the number of edges from the edge where the
//                RAM samples the address to the edge where mem_rdata is
//                valid.
//
// All outputs are registered. Once DONE is reached, the stage stays there
// until reset.
// ---------------------------------------------------------------------------
module mem_access #(
    parameter int ADDR_W     = 12,
    parameter int RD_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rstn,
    mem_access_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t            state_reg;
    logic [2:0]        funct3_reg;
    logic [1:0]        lane_reg;
    logic              is_load_reg;
    logic [1:0]        wait_cnt_reg;

    logic              completed_reg;
    logic [31:0]       rd_reg;
    logic              fault_reg;
    logic              mem_en_reg;
    logic [3:0]        mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [31:0]       mem_wdata_reg;

    logic              fault_next;
    logic [3:0]        mem_we_next;
    logic [31:0]       mem_wdata_next;
    logic [31:0]       load_data_next;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;

    // Classify the request as presented at the enabling edge.
    always_comb begin
        fault_next = 1'b0;
        if (bus.is_load && bus.is_store) begin
            fault_next = 1'b1;
        end else if (bus.is_load &&
                     !(bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) begin
            fault_next = 1'b1;
        end else if (bus.is_store && !(bus.funct3 inside {3'b000, 3'b001, 3'b010})) begin
            fault_next = 1'b1;
        end else if ((bus.is_load || bus.is_store) && bus.funct3[1:0] == 2'b01 && bus.addr[0]) begin
            fault_next = 1'b1;
        end else if ((bus.is_load || bus.is_store) && bus.funct3[1:0] == 2'b10 &&
                     bus.addr[1:0] != 2'b00) begin
            fault_next = 1'b1;
        end
    end

    // Narrow stores replicate the data into every lane, so the write enables
    // alone select which bytes land in the RAM.
    always_comb begin
        mem_we_next    = 4'b1111;
        mem_wdata_next = bus.wdata;
        case (bus.funct3[1:0])
            2'b00: begin
                mem_we_next    = 4'b0001 << bus.addr[1:0];
                mem_wdata_next = {4{bus.wdata[7:0]}};
            end
            2'b01: begin
                mem_we_next    = 4'b0011 << bus.addr[1:0];
                mem_wdata_next = {2{bus.wdata[15:0]}};
            end
            default: begin
                mem_we_next    = 4'b1111;
                mem_wdata_next = bus.wdata;
            end
        endcase
    end

    // Lane extraction for loads uses the request latched at the enabling
    // edge, because the live inputs may already belong to the next
    // instruction.
    always_comb begin
        byte_sel = bus.mem_rdata[{lane_reg, 3'b000} +: 8];
        half_sel = lane_reg[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (funct3_reg)
            3'b000:  load_data_next = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data_next = {24'd0, byte_sel};
            3'b001:  load_data_next = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data_next = {16'd0, half_sel};
            default: load_data_next = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            funct3_reg    <= 3'd0;
            lane_reg      <= 2'd0;
            is_load_reg   <= 1'b0;
            wait_cnt_reg  <= 2'd0;
            completed_reg <= 1'b0;
            rd_reg        <= 32'd0;
            fault_reg     <= 1'b0;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 4'd0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.enabled) begin
                        funct3_reg   <= bus.funct3;
                        lane_reg     <= bus.addr[1:0];
                        is_load_reg  <= bus.is_load;
                        mem_addr_reg <= bus.addr[ADDR_W+1:2];
                        if ((!bus.is_load && !bus.is_store) || fault_next) begin
                            // completed rises one edge later, from DONE.
                            rd_reg    <= bus.alu_result;
                            fault_reg <= fault_next;
                            state_reg <= DONE;
                        end else begin
                            mem_en_reg    <= 1'b1;
                            mem_we_reg    <= bus.is_store ? mem_we_next : 4'd0;
                            mem_wdata_reg <= bus.is_store ? mem_wdata_next : 32'd0;
                            state_reg     <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // The RAM samples the strobe on this edge.
                    mem_en_reg <= 1'b0;
                    mem_we_reg <= 4'd0;
                    if (is_load_reg) begin
                        wait_cnt_reg <= 2'(RD_LATENCY - 1);
                        state_reg    <= WAIT;
                    end else begin
                        rd_reg        <= 32'd0;
                        completed_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                WAIT: begin
                    if (wait_cnt_reg == 2'd0) begin
                        rd_reg        <= load_data_next;
                        completed_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 2'd1;
                    end
                end
                DONE: begin
                    completed_reg <= 1'b1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.completed = completed_reg;
    assign bus.rd        = rd_reg;
    assign bus.fault     = fault_reg;
    assign bus.mem_en    = mem_en_reg;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
endmodule

// File: tb/tb_mem_access.sv
// ---------------------------------------------------------------------------
// tb_mem_access
// Testbench for the mem_access stage. It runs two instances of the stage:
//   - unit 0 with RD_LATENCY = 1;
//   - unit 1 with RD_LATENCY = 3.
// Each unit has its own behavioural data RAM.
//
// Each transaction has its expectations worked out from the architectural
// rules before it starts:
//   - the fault rules;
//   - lane extraction and extension;
//   - the byte merge for stores;
//   - the completion latency.
// The observed results are then compared against those expectations.
// ---------------------------------------------------------------------------
module tb_mem_access;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk;
    logic rstn;

    // Request inputs, shared by both units; only the selected unit is enabled
    logic        en_s [2];
    logic        is_load_s;
    logic        is_store_s;
    logic [2:0]  funct3_s;
    logic [31:0] addr_s;
    logic [31:0] wdata_s;
    logic [31:0] alu_s;

    // Per-unit observed outputs
    logic              comp   [2];
    logic [31:0]       rdo    [2];
    logic              flt    [2];
    logic              men    [2];
    logic [3:0]        mwe    [2];
    logic [ADDR_W-1:0] maddr  [2];
    logic [31:0]       mwdata [2];
    logic [31:0]       rdata  [2];

    // Behavioural RAMs with a read pipeline and a backdoor preload port
    logic [31:0]       ram  [2][DEPTH];
    logic [31:0]       pipe [2][3];
    logic              bd_we;
    int                bd_u;
    logic [ADDR_W-1:0] bd_addr;
    logic [31:0]       bd_data;

    // Bus monitor: counts strobes and captures the last strobe seen
    int                en_cnt    [2];
    logic [3:0]        cap_we    [2];
    logic [ADDR_W-1:0] cap_addr  [2];
    logic [31:0]       cap_wdata [2];

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_unit
        mem_access_if #(.ADDR_W(ADDR_W)) bus ();

        mem_access #(
            .ADDR_W    (ADDR_W),
            .RD_LATENCY(gi == 0 ? 1 : 3)
        ) dut (
            .clk (clk),
            .rstn(rstn),
            .bus (bus)
        );

        assign bus.enabled    = en_s[gi];
        assign bus.is_load    = is_load_s;
        assign bus.is_store   = is_store_s;
        assign bus.funct3     = funct3_s;
        assign bus.addr       = addr_s;
        assign bus.wdata      = wdata_s;
        assign bus.alu_result = alu_s;
        assign bus.mem_rdata  = rdata[gi];

        assign comp[gi]   = bus.completed;
        assign rdo[gi]    = bus.rd;
        assign flt[gi]    = bus.fault;
        assign men[gi]    = bus.mem_en;
        assign mwe[gi]    = bus.mem_we;
        assign maddr[gi]  = bus.mem_addr;
        assign mwdata[gi] = bus.mem_wdata;
    end

    // The read data leaves the end of the pipeline:
    //   - stage 0 for latency 1;
    //   - stage 2 for latency 3.
    assign rdata[0] = pipe[0][0];
    assign rdata[1] = pipe[1][2];

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (men[u]) begin
                pipe[u][0] <= ram[u][maddr[u]];
                for (int b = 0; b < 4; b++)
                    if (mwe[u][b]) ram[u][maddr[u]][8*b +: 8] <= mwdata[u][8*b +: 8];
            end else begin
                pipe[u][0] <= 32'hBAD0_BAD0;
            end
            pipe[u][1] <= pipe[u][0];
            pipe[u][2] <= pipe[u][1];
        end
        if (bd_we) ram[bd_u][bd_addr] <= bd_data;
    end

    initial begin
        for (int u = 0; u < 2; u++) en_cnt[u] = 0;
    end

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (men[u] === 1'b1) begin
                en_cnt[u]    <= en_cnt[u] + 1;
                cap_we[u]    <= mwe[u];
                cap_addr[u]  <= maddr[u];
                cap_wdata[u] <= mwdata[u];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit ref_fault(bit ld, bit st, logic [2:0] f3, logic [31:0] a);
        int w;
        w = f3 & 3;
        if (!ld && !st) return 1'b0;
        if (ld && st) return 1'b1;
        if (ld && !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) return 1'b1;
        if (st && f3 > 2) return 1'b1;
        if (w == 1 && (a % 2) != 0) return 1'b1;
        if (w == 2 && (a % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(logic [2:0] f3, int off, logic [31:0] word);
        logic [31:0] b, h;
        b = (word >> (8 * off)) & 32'hFF;
        h = (word >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b > 127) ? b - 32'd256 : b;
            3'b100:  return b;
            3'b001:  return (h > 32767) ? h - 32'd65536 : h;
            3'b101:  return h;
            default: return word;
        endcase
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic bd_write(input int u, input int idx, input logic [31:0] d);
        bd_u    = u;
        bd_addr = ADDR_W'(idx);
        bd_data = d;
        bd_we   = 1'b1;
        @(negedge clk);
        bd_we   = 1'b0;
    endtask

    task automatic scramble();
        is_load_s  = 1'($urandom);
        is_store_s = 1'($urandom);
        funct3_s   = 3'($urandom);
        addr_s     = $urandom;
        wdata_s    = $urandom;
        alu_s      = $urandom;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic check_zero(input int u, input string tag);
        check({tag, "_completed"}, 32'(comp[u]), 32'd0);
        check({tag, "_rd"},        rdo[u],        32'd0);
        check({tag, "_fault"},     32'(flt[u]),   32'd0);
        check({tag, "_mem_en"},    32'(men[u]),   32'd0);
        check({tag, "_mem_we"},    32'(mwe[u]),   32'd0);
        check({tag, "_mem_addr"},  32'(maddr[u]), 32'd0);
        check({tag, "_mem_wdata"}, mwdata[u],     32'd0);
    endtask

    // One transaction on unit u. The model fixes its expectations before
    // enabled is raised.
    task automatic run_op(input int u, input bit rst_first, input bit ld, input bit st,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] alu);
        int          lat, n, off, idx, en0, exp_lat, exp_en;
        bit          xf, mem_op;
        logic [31:0] old_word, exp_rd, mask, exp_wdata, exp_word, rd_done;
        logic [3:0]  exp_we;

        lat      = (u == 0) ? 1 : 3;
        idx      = int'(a >> 2) % DEPTH;
        off      = int'(a % 4);
        old_word = ram[u][idx];
        xf       = ref_fault(ld, st, f3, a);
        mem_op   = (ld || st) && !xf;
        exp_en   = mem_op ? 1 : 0;
        exp_lat  = (mem_op && ld) ? 1 + lat : 1;

        case (f3 & 3'd3)
            3'd0: begin
                mask = 32'hFF << (8 * off);
                exp_we = 4'(1 << off);
                exp_wdata = (wd & 32'hFF) * 32'h0101_0101;
            end
            3'd1: begin
                mask = 32'hFFFF << (8 * off);
                exp_we = 4'(3 << off);
                exp_wdata = (wd & 32'hFFFF) * 32'h0001_0001;
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                exp_we = 4'hF;
                exp_wdata = wd;
            end
        endcase
        exp_word = (old_word & ~mask) | (exp_wdata & mask);

        if (!mem_op)  exp_rd = alu;
        else if (st)  exp_rd = 32'd0;
        else          exp_rd = ref_load(f3, off, old_word);

        if (rst_first) do_reset();
        en0 = en_cnt[u];

        is_load_s  = ld;
        is_store_s = st;
        funct3_s   = f3;
        addr_s     = a;
        wdata_s    = wd;
        alu_s      = alu;
        en_s[u]    = 1'b1;
        @(negedge clk);                 // E0 has passed
        en_s[u] = 1'b0;
        scramble();

        n = 0;
        while (comp[u] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        rd_done = rdo[u];

        check("latency",    32'(n),             32'(exp_lat));
        check("rd",         rd_done,            exp_rd);
        check("fault",      32'(flt[u]),        32'(xf));
        check("mem_en_cnt", 32'(en_cnt[u]-en0), 32'(exp_en));
        if (mem_op) begin
            check("mem_addr", 32'(cap_addr[u]), 32'(idx));
            check("mem_we",   32'(cap_we[u]),   st ? 32'(exp_we) : 32'd0);
            if (st) begin
                check("mem_wdata", cap_wdata[u], exp_wdata);
                check("ram_word",  ram[u][idx],  exp_word);
            end
        end

        // A second enable while in DONE must be ignored.
        en_s[u] = 1'b1;
        repeat (2) @(negedge clk);
        en_s[u] = 1'b0;
        check("done_hold_completed", 32'(comp[u]),   32'd1);
        check("done_hold_rd",        rdo[u],         rd_done);
        check("done_hold_no_access", 32'(en_cnt[u]), 32'(en0 + exp_en));

        $display("op unit=%0d ld=%0d st=%0d f3=%0d addr=0x%08h rd=0x%08h exp=0x%08h fault=%0d lat=%0d",
                 u, ld, st, f3, a, rd_done, exp_rd, flt[u], n);
    endtask

    // Watchdog so the bench always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int u, kind;
        logic [2:0]  f3;
        logic [31:0] a;

        rstn  = 1'b0;
        bd_we = 1'b0;
        bd_u  = 0;
        bd_addr = '0;
        bd_data = 32'd0;
        en_s[0] = 1'b0;
        en_s[1] = 1'b0;
        scramble();
        repeat (2) @(negedge clk);
        check_zero(0, "reset_u0");
        check_zero(1, "reset_u1");
        rstn = 1'b1;

        // Directed cases
        bd_write(0, 4, 32'hDEAD_BEEF);
        run_op(0, 1, 1, 0, 3'b010, 32'h10, 32'h0, 32'h5555_0000);
        bd_write(0, 4, 32'h80FF_1234);
        run_op(0, 1, 1, 0, 3'b000, 32'h13, 32'h0, 32'h0);
        run_op(0, 1, 1, 0, 3'b100, 32'h13, 32'h0, 32'h0);
        run_op(0, 1, 1, 0, 3'b001, 32'h12, 32'h0, 32'h0);
        bd_write(0, 8, 32'h1122_3344);
        run_op(0, 1, 0, 1, 3'b000, 32'h21, 32'h0000_00AB, 32'h0);
        run_op(0, 1, 1, 0, 3'b010, 32'h2, 32'h0, 32'hA5A5_0001);
        run_op(0, 1, 0, 1, 3'b001, 32'h5, 32'h0, 32'hA5A5_0002);
        run_op(1, 1, 0, 0, 3'b010, 32'h40, 32'h0, 32'h1234_5678);
        bd_write(1, 7, 32'hCAFE_F00D);
        run_op(1, 1, 1, 0, 3'b010, 32'h1C, 32'h0, 32'h0);
        run_op(1, 1, 0, 1, 3'b001, 32'h1E, 32'h0000_BEEF, 32'h0);
        run_op(0, 1, 1, 1, 3'b010, 32'h20, 32'h0, 32'h0BAD_0BAD);

        // Reset while a latency-3 load sits in WAIT
        do_reset();
        bd_write(1, 9, 32'h0F0F_F0F0);
        is_load_s = 1'b1; is_store_s = 1'b0; funct3_s = 3'b010;
        addr_s = 32'h24; wdata_s = 32'h0; alu_s = 32'h0;
        en_s[1] = 1'b1;
        @(negedge clk);
        en_s[1] = 1'b0;
        @(negedge clk);                 // E1 passed, now waiting
        rstn = 1'b0;
        @(negedge clk);
        check_zero(1, "midreset");
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        check("midreset_stays_idle", 32'(comp[1]), 32'd0);
        bd_write(1, 10, 32'h8001_7FFE);
        run_op(1, 0, 1, 0, 3'b101, 32'h2A, 32'h0, 32'h0);

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            u    = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 9));
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & 32'h0000_3FFF;
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom);
            else if (kind < 5) f3 = (kind % 2 == 0) ? 3'b010 : 3'($urandom_range(0, 1) * 4);
            else f3 = 3'($urandom_range(0, 2));
            bd_write(u, int'(a >> 2) % DEPTH, $urandom);
            if (kind < 5)       run_op(u, 1, 1, 0, f3, a, $urandom, $urandom);
            else if (kind < 9)  run_op(u, 1, 0, 1, f3, a, $urandom, $urandom);
            else                run_op(u, 1, 0, 0, f3, a, $urandom, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
